fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction RAM. It holds the program counter and drives the RAM's address and read-enable. It captures the 16-bit instruction word one cycle later and presents it to the decode/control stage through a valid/ready handshake. It also accepts branch redirects from the consumer.

## Interface
- ADDR_W, 9: instruction address width; matches the RAM address port.
- DATA_W, 16: instruction word width.
- RESET_PC, 1: PC value after reset; this is the first program word.
- HALT_WORD, 16'hFFFF: halt encoding, used only when FETCH_HALT_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins fetching from the current PC when in IDLE.
- iram_addr  out  ADDR_W  RAM address; equals pc.
- iram_read_en  out  1  RAM read enable; high only in FETCH.
- iram_data  in  DATA_W  RAM read data; valid the cycle after read_en.
- ir_out  out  DATA_W  captured instruction.
- ir_valid  out  1  ir_out holds an unconsumed instruction.
- ir_ready  in  1  consumer accepts ir_out when ir_valid && ir_ready.
- branch_en  in  1  redirect the PC; sampled only on acceptance.
- branch_addr  in  ADDR_W  redirect target.
- pc_out  out  ADDR_W  address of the instruction currently in ir_out.
- halted  out  1  halt word reached (FETCH_HALT_EN only).

## Operation
- States: IDLE, FETCH, CAPTURE, HOLD, and HALTED (HALTED exists only with the macro).
- IDLE: all handshake outputs are low. On start, go to FETCH. start is ignored in every other state.
- FETCH: iram_read_en=1 and iram_addr=pc. Always go to CAPTURE on the next cycle.
- CAPTURE:
  - ir_out <= iram_data and pc_out <= pc.
  - pc <= pc+1, modulo 2^ADDR_W; 511 wraps to 0.
  - ir_valid <= 1, then go to HOLD.
- HOLD: ir_out, pc_out and ir_valid stay stable until acceptance.
- On acceptance (ir_valid && ir_ready):
  - ir_valid <= 0 and the state goes to FETCH.
  - If branch_en is high in the same cycle, pc <= branch_addr; this overrides the incremented PC.
- branch_en is ignored when there is no acceptance.
- iram_read_en is never high while ir_valid is high. The RAM is never written by this block.

## Timing
- Reset values (asynchronous): state=IDLE, pc=RESET_PC, ir_out=0, pc_out=0, ir_valid=0, halted=0.
- During reset, iram_read_en=0 and iram_addr=RESET_PC.
- start sampled high in cycle N:
  - FETCH in N+1.
  - CAPTURE in N+2.
  - ir_valid high from N+3.
- Acceptance in cycle M: ir_valid is low in M+1 and M+2, then high again in M+3.
- Throughput is one instruction per 3 cycles when ir_ready is held high.
- ir_ready held low: the output holds indefinitely, with no further RAM reads.
- Reset asserted mid-fetch: the next state is IDLE immediately. Any in-flight RAM read is discarded.

## Configuration
- FETCH_HALT_EN defined:
  - In CAPTURE, if iram_data == HALT_WORD, the state goes to HALTED and halted=1.
  - ir_valid stays 0 and pc is not incremented.
  - HALTED exits only through rst_n.
- FETCH_HALT_EN undefined:
  - halted is tied to 0.
  - HALT_WORD is treated as an ordinary instruction.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, FETCH, CAPTURE, HOLD, HALTED);
  - the ADDR_W and DATA_W defaults;
  - the HALT_WORD default constant.
- One sub-module, fetch_pc, holds the PC register with its increment/wrap and branch load. The FSM stays in fetch_unit.

## Test plan
All scenarios use RAM preload [1]=16'd0, [2]=16'd1025, [3]=16'd2050, [4]=16'd5120, [5]=16'd3075.
- Reset then start, ir_ready=1:
  - ir_out sequence is 0, 1025, 2050, 5120, 3075.
  - pc_out sequence is 1..5.
  - ir_valid rises every 3 cycles; the first rise is 3 cycles after start.
- Backpressure: hold ir_ready=0 for 10 cycles after the first ir_valid.
  - ir_out stays 0 with pc_out=1.
  - iram_read_en stays 0 throughout.
  - On release, the next word is 1025.
- Branch: accept the word at pc_out=2 with branch_en=1 and branch_addr=5.
  - The next ir_out is 3075 with pc_out=5.
- Wrap: RESET_PC=511 with RAM[0]=16'd7.
  - After the word at 511, the next word is 7 with pc_out=0.
- Reset mid-operation: assert rst_n=0 during CAPTURE.
  - Outputs return to their reset values in the same cycle.
  - After release plus start, the fetch restarts at address 1.
- With FETCH_HALT_EN and RAM[3]=16'hFFFF:
  - Words 0 and 1025 are delivered.
  - halted=1 and ir_valid stays 0 permanently.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default bus widths and the halt instruction encoding.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 32'd9;
  localparam int unsigned DATA_W_DEFAULT = 32'd16;
  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    HALTED  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch stage, the instruction RAM and the
// decode/control consumer. The master modport is the fetch stage side.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);
  logic [ADDR_W-1:0] iram_addr;
  logic              iram_read_en;
  logic [DATA_W-1:0] iram_data;
  logic [DATA_W-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ready;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    output iram_addr, iram_read_en, ir_out, ir_valid, pc_out,
    input  iram_data, ir_ready, branch_en, branch_addr
  );

  modport slave (
    input  iram_addr, iram_read_en, ir_out, ir_valid, pc_out,
    output iram_data, ir_ready, branch_en, branch_addr
  );
endinterface

// File: rtl/fetch_pc.sv
// Program counter register: increments with natural wrap at 2^ADDR_W and
// loads a branch target. A load takes priority over an increment.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned RESET_PC = 32'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_en,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_r;

  // PC update: branch load, else increment, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= ADDR_W'(RESET_PC);
    end else if (load_en) begin
      pc_r <= load_addr;
    end else if (inc_en) begin
      pc_r <= pc_r + ADDR_W'(1'b1);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Drives the instruction RAM address/read enable,
// captures the returned word one cycle later and offers it to the consumer
// over a valid/ready handshake; branch redirects are taken on acceptance.
// Optional feature macro: FETCH_HALT_EN (stop fetching on the halt word).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned RESET_PC = 32'd1
`ifdef FETCH_HALT_EN
  , parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEFAULT)
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start,
  fetch_if.master  bus,
  output logic     halted
);

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  logic              accept_s;
  logic              capture_s;
  logic              pc_inc_s;
  logic              pc_load_s;
  logic              read_en_r;
  logic              ir_valid_r;
  logic [DATA_W-1:0] ir_out_r;
  logic [ADDR_W-1:0] pc_out_r;
  logic [ADDR_W-1:0] pc_s;
`ifdef FETCH_HALT_EN
  logic              halt_hit_s;
  logic              halted_r;
`endif

  assign accept_s = ir_valid_r && bus.ir_ready;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (pc_inc_s),
    .load_en   (pc_load_s),
    .load_addr (bus.branch_addr),
    .pc        (pc_s)
  );

  // Next-state and control decode for the fetch sequencer
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    pc_inc_s     = 1'b0;
    pc_load_s    = 1'b0;
`ifdef FETCH_HALT_EN
    halt_hit_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        state_next_s = CAPTURE;
      end
      CAPTURE: begin
`ifdef FETCH_HALT_EN
        if (bus.iram_data == HALT_WORD) begin
          state_next_s = HALTED;
          halt_hit_s   = 1'b1;
        end else begin
          state_next_s = HOLD;
          capture_s    = 1'b1;
          pc_inc_s     = 1'b1;
        end
`else
        state_next_s = HOLD;
        capture_s    = 1'b1;
        pc_inc_s     = 1'b1;
`endif
      end
      HOLD: begin
        if (accept_s) begin
          state_next_s = FETCH;
          pc_load_s    = bus.branch_en;
        end else begin
          state_next_s = HOLD;
        end
      end
`ifdef FETCH_HALT_EN
      HALTED: begin
        state_next_s = HALTED;
      end
`endif
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register plus read enable registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      read_en_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      read_en_r <= (state_next_s == FETCH);
    end
  end

  // Instruction register, its address and the valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_out_r   <= '0;
      pc_out_r   <= '0;
      ir_valid_r <= 1'b0;
    end else if (capture_s) begin
      ir_out_r   <= bus.iram_data;
      pc_out_r   <= pc_s;
      ir_valid_r <= 1'b1;
    end else if (accept_s) begin
      ir_valid_r <= 1'b0;
    end else begin
      ir_valid_r <= ir_valid_r;
    end
  end

`ifdef FETCH_HALT_EN
  // Sticky halt flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_r <= 1'b0;
    end else if (halt_hit_s) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end
  assign halted = halted_r;
`else
  assign halted = 1'b0;
`endif

  assign bus.iram_addr    = pc_s;
  assign bus.iram_read_en = read_en_r;
  assign bus.ir_out       = ir_out_r;
  assign bus.pc_out       = pc_out_r;
  assign bus.ir_valid     = ir_valid_r;

endmodule
